// File: rtl/escalonador_chamadas_pkg.sv
// Shared definitions for the elevator: floor count, scheduler and car
// state encodings, and travel direction constants.
package pkg_elevador;

  localparam int N_ANDARES = 5;
  localparam int W_ANDAR   = 3;

  // Scheduler states (value is exposed on estado_esc)
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    MOVENDO = 2'b01,
    PORTA   = 2'b10,
    EMERG   = 2'b11
  } estado_esc_t;

  // Car controller states, kept here so both blocks share one definition
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } estado_carro_t;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

endpackage

// File: rtl/escalonador_chamadas_seletor_alvo.sv
// seletor_alvo: combinational nearest-call search around the current floor.
// Ports:
//   i_pendentes  - pending call bits
//   i_andar_atual- current floor
//   i_limite     - exclusive bound; only floors strictly between the
//                  current floor and the bound are considered on the bound's
//                  side. A bound on the other side (or equal) leaves that
//                  search unbounded.
//   o_found_up/o_alvo_up - nearest pending floor above
//   o_found_dn/o_alvo_dn - nearest pending floor below
module seletor_alvo
  import pkg_elevador::*;
(
  input  logic [N_ANDARES-1:0] i_pendentes,
  input  logic [W_ANDAR-1:0]   i_andar_atual,
  input  logic [W_ANDAR-1:0]   i_limite,
  output logic                 o_found_up,
  output logic [W_ANDAR-1:0]   o_alvo_up,
  output logic                 o_found_dn,
  output logic [W_ANDAR-1:0]   o_alvo_dn
);

  logic [N_ANDARES-1:0] w_cand_up;
  logic [N_ANDARES-1:0] w_cand_dn;

  for (genvar gi = 0; gi < N_ANDARES; gi++) begin : g_cand
    localparam logic [W_ANDAR-1:0] IDX = W_ANDAR'(gi);
    assign w_cand_up[gi] = i_pendentes[gi] && (IDX > i_andar_atual) &&
                           ((IDX < i_limite) || (i_limite <= i_andar_atual));
    assign w_cand_dn[gi] = i_pendentes[gi] && (IDX < i_andar_atual) &&
                           ((IDX > i_limite) || (i_limite >= i_andar_atual));
  end

  // Upward scan runs high-to-low so the lowest candidate wins; downward
  // scan runs low-to-high so the highest candidate wins.
  always_comb begin
    o_found_up = 1'b0;
    o_alvo_up  = '0;
    o_found_dn = 1'b0;
    o_alvo_dn  = '0;
    for (int i = N_ANDARES - 1; i >= 0; i--) begin
      if (w_cand_up[i]) begin
        o_found_up = 1'b1;
        o_alvo_up  = W_ANDAR'(i);
      end
    end
    for (int i = 0; i < N_ANDARES; i++) begin
      if (w_cand_dn[i]) begin
        o_found_dn = 1'b1;
        o_alvo_dn  = W_ANDAR'(i);
      end
    end
  end

endmodule

// File: rtl/escalonador_chamadas.sv
// escalonador_chamadas: SCAN call scheduler for the elevator car.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   emergencia         - level, forces return to floor 0
//   chamada            - call buttons, bit i = floor i
//   andar_atual        - floor sensor
//   motor_liga         - car motor-on feedback (door interlock)
//   andar_requisitado  - destination driven to the car FSM
//   porta_aberta       - door open command (registered)
//   pendentes          - latched pending calls
//   estado_esc         - scheduler state
module escalonador_chamadas
  import pkg_elevador::*;
#(
  parameter int T_PORTA = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 emergencia,
  input  logic [N_ANDARES-1:0] chamada,
  input  logic [W_ANDAR-1:0]   andar_atual,
  input  logic                 motor_liga,
  output logic [W_ANDAR-1:0]   andar_requisitado,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pendentes,
  output logic [1:0]           estado_esc
);

  localparam int              W_T     = (T_PORTA > 2) ? $clog2(T_PORTA) : 1;
  localparam logic [W_T-1:0]  T_CARGA = W_T'(T_PORTA - 1);

  estado_esc_t          r_estado, w_estado_next;
  logic                 r_dir, w_dir_next;
  logic [W_ANDAR-1:0]   r_alvo, w_alvo_next;
  logic [W_T-1:0]       r_timer, w_timer_next;
  logic                 r_porta, w_porta_next;
  logic [N_ANDARES-1:0] r_pendentes, w_pendentes_next;
  logic [N_ANDARES-1:0] w_limpa;

  logic                 w_valido;
  logic [N_ANDARES-1:0] w_bit_atual;
  logic [W_ANDAR-1:0]   w_limite;
  logic                 w_found_up, w_found_dn;
  logic [W_ANDAR-1:0]   w_alvo_up, w_alvo_dn;

  assign w_valido    = ({1'b0, andar_atual} < (W_ANDAR + 1)'(N_ANDARES));
  assign w_bit_atual = w_valido ? ({{(N_ANDARES-1){1'b0}}, 1'b1} << andar_atual) : '0;

  // While moving, only floors strictly between here and the target are
  // pick-up candidates; when idle the search is unbounded.
  assign w_limite = (r_estado == MOVENDO) ? r_alvo : andar_atual;

  seletor_alvo u_seletor (
    .i_pendentes  (r_pendentes),
    .i_andar_atual(andar_atual),
    .i_limite     (w_limite),
    .o_found_up   (w_found_up),
    .o_alvo_up    (w_alvo_up),
    .o_found_dn   (w_found_dn),
    .o_alvo_dn    (w_alvo_dn)
  );

  always_comb begin
    w_estado_next = r_estado;
    w_dir_next    = r_dir;
    w_alvo_next   = r_alvo;
    w_timer_next  = r_timer;
    w_porta_next  = r_porta;
    w_limpa       = '0;

    if (emergencia) begin
      w_estado_next = EMERG;
      w_porta_next  = 1'b0;
      w_timer_next  = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_valido && (r_pendentes != '0)) begin
            if ((r_pendentes & w_bit_atual) != '0) begin
              w_estado_next = PORTA;
              w_timer_next  = T_CARGA;
              w_porta_next  = 1'b1;
              w_limpa       = w_bit_atual;
            end else begin
              w_estado_next = MOVENDO;
              if (r_dir == SOBE) begin
                if (w_found_up) begin
                  w_alvo_next = w_alvo_up;
                end else begin
                  w_alvo_next = w_alvo_dn;
                  w_dir_next  = DESCE;
                end
              end else begin
                if (w_found_dn) begin
                  w_alvo_next = w_alvo_dn;
                end else begin
                  w_alvo_next = w_alvo_up;
                  w_dir_next  = SOBE;
                end
              end
            end
          end
        end
        MOVENDO: begin
          if (w_valido) begin
            if (andar_atual == r_alvo) begin
              w_estado_next = PORTA;
              w_timer_next  = T_CARGA;
              w_porta_next  = 1'b1;
              w_limpa       = w_bit_atual;
            end else if ((r_dir == SOBE) && w_found_up) begin
              w_alvo_next = w_alvo_up;
            end else if ((r_dir == DESCE) && w_found_dn) begin
              w_alvo_next = w_alvo_dn;
            end
          end
        end
        PORTA: begin
          // Calls for this floor are absorbed and keep the door open longer
          w_limpa = w_bit_atual;
          if ((chamada & w_bit_atual) != '0) begin
            w_timer_next = T_CARGA;
          end else if (r_timer != '0) begin
            w_timer_next = r_timer - 1'b1;
          end else if (!motor_liga) begin
            w_estado_next = OCIOSO;
            w_porta_next  = 1'b0;
          end
        end
        EMERG: begin
          if (andar_atual == '0) begin
            w_estado_next = PORTA;
            w_timer_next  = T_CARGA;
            w_porta_next  = 1'b1;
            w_limpa       = w_bit_atual;
          end
        end
        default: ;
      endcase
    end

    if (emergencia || (r_estado == EMERG)) begin
      w_pendentes_next = '0;
    end else begin
      w_pendentes_next = (r_pendentes | chamada) & ~w_limpa;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_dir       <= SOBE;
      r_alvo      <= '0;
      r_timer     <= '0;
      r_porta     <= 1'b0;
      r_pendentes <= '0;
    end else begin
      r_estado    <= w_estado_next;
      r_dir       <= w_dir_next;
      r_alvo      <= w_alvo_next;
      r_timer     <= w_timer_next;
      r_porta     <= w_porta_next;
      r_pendentes <= w_pendentes_next;
    end
  end

  always_comb begin
    case (r_estado)
      MOVENDO: andar_requisitado = r_alvo;
      EMERG:   andar_requisitado = '0;
      default: andar_requisitado = andar_atual;
    endcase
  end

  assign porta_aberta = r_porta;
  assign pendentes    = r_pendentes;
  assign estado_esc   = r_estado;

endmodule

// File: tb/tb_escalonador_chamadas.sv
module tb_escalonador_chamadas;
  import pkg_elevador::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 emergencia;
  logic [N_ANDARES-1:0] chamada;
  logic [W_ANDAR-1:0]   andar_atual;
  logic                 motor_liga;
  logic [W_ANDAR-1:0]   andar_requisitado;
  logic                 porta_aberta;
  logic [N_ANDARES-1:0] pendentes;
  logic [1:0]           estado_esc;

  escalonador_chamadas #(.T_PORTA(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .emergencia       (emergencia),
    .chamada          (chamada),
    .andar_atual      (andar_atual),
    .motor_liga       (motor_liga),
    .andar_requisitado(andar_requisitado),
    .porta_aberta     (porta_aberta),
    .pendentes        (pendentes),
    .estado_esc       (estado_esc)
  );

  always #5 clock = ~clock;

  localparam int SIG_EST = 0, SIG_REQ = 1, SIG_PORTA = 2, SIG_PEND = 3;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } esperado_t;

  esperado_t sb_q[$];
  int        n_assert = 0;
  int        n_fail   = 0;
  string     fase     = "init";
  int        ciclo    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got=%0d expected=%0d (cycle %0d)", fase, tag, got, exp, ciclo);
    end
  endtask

  task automatic push(input string tag, input int sig, input int val);
    esperado_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic exp_out(input int est, input int req, input int porta);
    if (est >= 0)   push("estado", SIG_EST, est);
    if (req >= 0)   push("req", SIG_REQ, req);
    if (porta >= 0) push("porta", SIG_PORTA, porta);
  endtask

  task automatic exp_pend(input int pend);
    push("pend", SIG_PEND, pend);
  endtask

  // Advance one edge, then pop and compare every expectation queued for it
  task automatic tick();
    esperado_t e;
    int        got;
    @(posedge clock);
    #1;
    ciclo++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SIG_EST:   got = int'(estado_esc);
        SIG_REQ:   got = int'(andar_requisitado);
        SIG_PORTA: got = int'(porta_aberta);
        default:   got = int'(pendentes);
      endcase
      check_val(e.tag, got, e.val);
    end
    $display("[cyc %0d] %s atual=%0d est=%0d req=%0d porta=%0b pend=%b",
             ciclo, fase, andar_atual, estado_esc, andar_requisitado, porta_aberta, pendentes);
  endtask

  // Remaining 7 door cycles after entry, then the exit to OCIOSO
  task automatic run_dwell();
    for (int i = 0; i < 7; i++) begin
      exp_out(2, -1, 1);
      tick();
    end
    exp_out(0, int'(andar_atual), 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; emergencia = 1'b0; chamada = '0; andar_atual = 3'd2; motor_liga = 1'b0;

    fase = "reset";
    exp_out(0, 2, 0); exp_pend(0);
    tick();
    reset = 1'b0;

    fase = "call4";
    andar_atual = 3'd0; chamada = 5'b10000;
    exp_out(0, 0, 0); exp_pend(5'b10000);
    tick();
    chamada = '0;
    exp_out(1, 4, 0);
    tick();
    exp_out(1, 4, 0);
    tick();
    andar_atual = 3'd4;
    exp_out(2, 4, 1); exp_pend(0);
    tick();
    run_dwell();

    fase = "pickup";
    andar_atual = 3'd0; chamada = 5'b10000;
    exp_out(0, 0, 0); exp_pend(5'b10000);
    tick();
    chamada = '0;
    exp_out(1, 4, 0);
    tick();
    andar_atual = 3'd1;
    exp_out(1, 4, 0);
    tick();
    chamada = 5'b00100;
    exp_out(1, 4, -1); exp_pend(5'b10100);
    tick();
    chamada = '0;
    exp_out(1, 2, 0);
    tick();
    andar_atual = 3'd2;
    exp_out(2, 2, 1); exp_pend(5'b10000);
    tick();
    run_dwell();
    exp_out(1, 4, 0);
    tick();
    andar_atual = 3'd4;
    exp_out(2, 4, 1); exp_pend(0);
    tick();
    run_dwell();

    fase = "reverse";
    andar_atual = 3'd2; chamada = 5'b00001;
    exp_out(0, 2, -1); exp_pend(5'b00001);
    tick();
    chamada = '0;
    exp_out(1, 0, 0);
    tick();
    andar_atual = 3'd0;
    exp_out(2, 0, 1); exp_pend(0);
    tick();
    run_dwell();
    chamada = 5'b00100;
    tick();
    chamada = '0;
    exp_out(1, 2, 0);
    tick();
    andar_atual = 3'd2;
    exp_out(2, 2, 1);
    tick();
    run_dwell();
    fase = "keepdir";
    chamada = 5'b10001;
    exp_pend(5'b10001);
    tick();
    chamada = '0;
    exp_out(1, 4, 0);
    tick();

    fase = "emerg";
    andar_atual = 3'd3;
    exp_out(1, 4, 0);
    tick();
    emergencia = 1'b1;
    exp_out(3, 0, 0); exp_pend(0);
    tick();
    chamada = 5'b00110;
    exp_out(3, 0, 0); exp_pend(0);
    tick();
    chamada = '0; emergencia = 1'b0;
    exp_out(3, 0, 0);
    tick();
    andar_atual = 3'd0;
    exp_out(2, 0, 1); exp_pend(0);
    tick();
    run_dwell();

    fase = "door_reload";
    chamada = 5'b00001;
    exp_out(0, 0, 0); exp_pend(5'b00001);
    tick();
    chamada = '0;
    exp_out(2, 0, 1); exp_pend(0);
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_out(2, -1, 1);
      tick();
    end
    chamada = 5'b00001;
    exp_out(2, 0, 1); exp_pend(0);
    tick();
    chamada = '0;
    run_dwell();

    fase = "interlock";
    chamada = 5'b00001;
    tick();
    chamada = '0;
    exp_out(2, -1, 1);
    tick();
    motor_liga = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_out(2, -1, 1);
      tick();
    end
    motor_liga = 1'b0;
    exp_out(0, 0, 0);
    tick();

    fase = "reset_porta";
    chamada = 5'b00001;
    tick();
    chamada = '0;
    exp_out(2, -1, 1);
    tick();
    chamada = 5'b00010;
    exp_out(2, -1, 1); exp_pend(5'b00010);
    tick();
    chamada = '0; reset = 1'b1;
    exp_out(0, 0, 0); exp_pend(0);
    tick();
    reset = 1'b0;

    fase = "invalid";
    chamada = 5'b01000;
    exp_pend(5'b01000);
    tick();
    chamada = '0; andar_atual = 3'd7;
    exp_out(0, 7, 0); exp_pend(5'b01000);
    tick();
    andar_atual = 3'd1;
    exp_out(1, 3, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
